// File: rtl/pipeline_stall_ctrl.sv
// ID-stage sequencer: per-stage load/flush enables for a 5-stage pipeline with
// priority memory wait > branch flush > data-hazard stall, plus timeout/deadlock detection.
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int HAZARD_MAX  = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             if_id_flush,
  output logic             id_ex_load,
  output logic             id_ex_flush,
  output logic             ex_mem_load,
  output logic             mem_wb_flush,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int HZ_W   = $clog2(HAZARD_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [HZ_W-1:0]   HZ_LIMIT   = HZ_W'(HAZARD_MAX - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_t;

  state_t            state_r, state_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_s;
  logic [HZ_W-1:0]   hz_cnt_r, hz_cnt_s;
  logic [1:0]        err_r, err_s;
  logic              flush_inc_s;
  logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Next-state, internal counters and combinational stage enables
  always_comb begin
    pc_load      = 1'b0;
    if_id_load   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_load   = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_load  = 1'b0;
    mem_wb_flush = 1'b0;
    state_s      = state_r;
    wait_cnt_s   = wait_cnt_r;
    hz_cnt_s     = hz_cnt_r;
    err_s        = err_r;
    flush_inc_s  = 1'b0;
    if (!reset) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (mem_req && !mem_ready) begin
            mem_wb_flush = 1'b1;
            state_s      = MEM_WAIT;
            wait_cnt_s   = WAIT_W'(1);
          end else if (branch_taken) begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc_s = 1'b1;
            hz_cnt_s    = {HZ_W{1'b0}};
          end else if (data_hazard) begin
            id_ex_flush = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            hz_cnt_s    = hz_cnt_r + HZ_W'(1);
            if (hz_cnt_r == HZ_LIMIT) begin
              err_s   = 2'b10;
              state_s = ERROR;
            end else begin
              state_s = RUN;
            end
          end else begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            hz_cnt_s    = {HZ_W{1'b0}};
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            state_s     = RUN;
            wait_cnt_s  = {WAIT_W{1'b0}};
          end else begin
            mem_wb_flush = 1'b1;
            if (wait_cnt_r == WAIT_LIMIT) begin
              err_s   = 2'b01;
              state_s = ERROR;
            end else begin
              wait_cnt_s = wait_cnt_r + WAIT_W'(1);
            end
          end
        end
        ERROR: begin
          state_s = ERROR;
        end
        default: begin
          // An illegal encoding freezes the pipeline until reset
          state_s = ERROR;
        end
      endcase
    end
  end

  // State, sticky error and saturating performance counters
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= RUN;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      hz_cnt_r    <= {HZ_W{1'b0}};
      err_r       <= 2'b00;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      hz_cnt_r   <= hz_cnt_s;
      err_r      <= err_s;
      if (!pc_load) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (flush_inc_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
    end
  end

  assign err          = err_r;
  assign stall_cycles = stall_cnt_r;
  assign flush_count  = flush_cnt_r;

endmodule
